// File: rtl/rat_gpr.sv
// rtl/rat_gpr.sv - register alias table and architectural GPR file
// Renames sources against in-flight ROB tags and retires committed results into the GPRs.
module rat_gpr #(
   parameter int GPR_ADDR_WIDTH = 5,
   parameter int ROB_TAG_WIDTH  = 5,
   parameter int WORD_WIDTH     = 32,
   parameter logic [WORD_WIDTH-1:0] EXP_VECTOR = 32'h0000_0100
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [GPR_ADDR_WIDTH-1:0] rs1_addr,
   input  logic [GPR_ADDR_WIDTH-1:0] rs2_addr,
   output logic                      rs1_rat_valid,
   output logic [ROB_TAG_WIDTH-1:0]  rs1_Paddr,
   output logic [WORD_WIDTH-1:0]     rs1_value_fromGPR,
   output logic                      rs2_rat_valid,
   output logic [ROB_TAG_WIDTH-1:0]  rs2_Paddr,
   output logic [WORD_WIDTH-1:0]     rs2_value_fromGPR,
   input  logic                      alloc_en,
   input  logic [ROB_TAG_WIDTH-1:0]  alloc_tag,
   input  logic [GPR_ADDR_WIDTH-1:0] alloc_dst_addr,
   input  logic                      alloc_dst_wen,
   input  logic                      commit_en,
   input  logic [ROB_TAG_WIDTH-1:0]  commit_tag,
   input  logic [GPR_ADDR_WIDTH-1:0] commit_dst_addr,
   input  logic                      commit_dst_wen,
   input  logic [WORD_WIDTH-1:0]     commit_dst_value,
   input  logic                      commit_br_taken,
   input  logic [WORD_WIDTH-1:0]     commit_br_addr,
   input  logic                      commit_exp_en,
   output logic                      flush,
   output logic [WORD_WIDTH-1:0]     redirect_pc,
   output logic [GPR_ADDR_WIDTH:0]   mapped_cnt
);

   localparam int NREG = 1 << GPR_ADDR_WIDTH;

   logic [NREG-1:0]          valid_q, valid_d;
   logic [ROB_TAG_WIDTH-1:0] tag_q [NREG];
   logic [WORD_WIDTH-1:0]    gpr_q [NREG];
   logic                     flush_q;
   logic [WORD_WIDTH-1:0]    redirect_pc_q;
   logic [GPR_ADDR_WIDTH:0]  mapped_cnt_q, mapped_cnt_d;

   logic commit_wr, alloc_wr, flush_cond, rs1_byp, rs2_byp;

   assign commit_wr  = commit_en && commit_dst_wen && (commit_dst_addr != '0);
   assign flush_cond = commit_en && (commit_br_taken || commit_exp_en);
   // A flushing commit squashes whatever was allocated alongside it.
   assign alloc_wr   = alloc_en && alloc_dst_wen && (alloc_dst_addr != '0) && !flush_cond;

   assign rs1_byp = commit_wr && (commit_dst_addr == rs1_addr) && (tag_q[rs1_addr] == commit_tag);
   assign rs2_byp = commit_wr && (commit_dst_addr == rs2_addr) && (tag_q[rs2_addr] == commit_tag);

   assign rs1_rat_valid     = valid_q[rs1_addr] && (rs1_addr != '0) && !rs1_byp;
   assign rs1_Paddr         = tag_q[rs1_addr];
   assign rs1_value_fromGPR = rs1_byp ? commit_dst_value : gpr_q[rs1_addr];
   assign rs2_rat_valid     = valid_q[rs2_addr] && (rs2_addr != '0) && !rs2_byp;
   assign rs2_Paddr         = tag_q[rs2_addr];
   assign rs2_value_fromGPR = rs2_byp ? commit_dst_value : gpr_q[rs2_addr];

   always_comb begin
      valid_d = valid_q;
      // Release only when the committing tag is still the live mapping.
      if (commit_wr && valid_q[commit_dst_addr] && (tag_q[commit_dst_addr] == commit_tag))
         valid_d[commit_dst_addr] = 1'b0;
      if (alloc_wr)
         valid_d[alloc_dst_addr] = 1'b1;
      if (flush_cond)
         valid_d = '0;
      mapped_cnt_d = '0;
      for (int i = 0; i < NREG; i++)
         mapped_cnt_d = mapped_cnt_d + {{GPR_ADDR_WIDTH{1'b0}}, valid_d[i]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q       <= '0;
         mapped_cnt_q  <= '0;
         flush_q       <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         valid_q      <= valid_d;
         mapped_cnt_q <= mapped_cnt_d;
         flush_q      <= flush_cond;
         if (flush_cond)
            redirect_pc_q <= commit_exp_en ? EXP_VECTOR : commit_br_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (alloc_wr)
         tag_q[alloc_dst_addr] <= alloc_tag;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++)
            gpr_q[i] <= '0;
      end else if (commit_wr) begin
         gpr_q[commit_dst_addr] <= commit_dst_value;
      end
   end

   assign flush       = flush_q;
   assign redirect_pc = redirect_pc_q;
   assign mapped_cnt  = mapped_cnt_q;

endmodule

// File: tb/tb_rat_gpr.sv
// tb/tb_rat_gpr.sv - directed self-checking bench for rat_gpr
module tb_rat_gpr;

   logic        clk, rst_n;
   logic [4:0]  rs1_addr, rs2_addr;
   logic        rs1_rat_valid, rs2_rat_valid;
   logic [4:0]  rs1_Paddr, rs2_Paddr;
   logic [31:0] rs1_value_fromGPR, rs2_value_fromGPR;
   logic        alloc_en, alloc_dst_wen;
   logic [4:0]  alloc_tag, alloc_dst_addr;
   logic        commit_en, commit_dst_wen, commit_br_taken, commit_exp_en;
   logic [4:0]  commit_tag, commit_dst_addr;
   logic [31:0] commit_dst_value, commit_br_addr;
   logic        flush;
   logic [31:0] redirect_pc;
   logic [5:0]  mapped_cnt;

   int vectors = 0;
   int miscompares = 0;

   rat_gpr dut (
      .clk(clk), .rst_n(rst_n),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_rat_valid(rs1_rat_valid), .rs1_Paddr(rs1_Paddr), .rs1_value_fromGPR(rs1_value_fromGPR),
      .rs2_rat_valid(rs2_rat_valid), .rs2_Paddr(rs2_Paddr), .rs2_value_fromGPR(rs2_value_fromGPR),
      .alloc_en(alloc_en), .alloc_tag(alloc_tag), .alloc_dst_addr(alloc_dst_addr),
      .alloc_dst_wen(alloc_dst_wen),
      .commit_en(commit_en), .commit_tag(commit_tag), .commit_dst_addr(commit_dst_addr),
      .commit_dst_wen(commit_dst_wen), .commit_dst_value(commit_dst_value),
      .commit_br_taken(commit_br_taken), .commit_br_addr(commit_br_addr),
      .commit_exp_en(commit_exp_en),
      .flush(flush), .redirect_pc(redirect_pc), .mapped_cnt(mapped_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alloc_en = 0; alloc_dst_wen = 0; alloc_tag = 0; alloc_dst_addr = 0;
      commit_en = 0; commit_dst_wen = 0; commit_tag = 0; commit_dst_addr = 0;
      commit_dst_value = 0; commit_br_taken = 0; commit_br_addr = 0; commit_exp_en = 0;
   endtask

   task automatic do_alloc(input logic [4:0] addr, input logic [4:0] tag);
      alloc_en = 1; alloc_dst_wen = 1; alloc_dst_addr = addr; alloc_tag = tag;
   endtask

   task automatic do_commit(input logic [4:0] addr, input logic [4:0] tag, input logic [31:0] val);
      commit_en = 1; commit_dst_wen = 1; commit_dst_addr = addr; commit_tag = tag;
      commit_dst_value = val;
   endtask

   initial begin
      rst_n = 0; rs1_addr = 5; rs2_addr = 0;
      idle();
      #12;
      chk("rst_flush", {31'd0, flush}, 0);
      chk("rst_redirect", redirect_pc, 0);
      chk("rst_cnt", {26'd0, mapped_cnt}, 0);
      chk("rst_rs1_valid", {31'd0, rs1_rat_valid}, 0);
      chk("rst_rs1_value", rs1_value_fromGPR, 0);
      rst_n = 1;
      tick();

      // allocate x5 -> tag 3; same-cycle lookup still sees the old map
      do_alloc(5, 3); rs1_addr = 5; #1;
      chk("alloc_pre_valid", {31'd0, rs1_rat_valid}, 0);
      tick(); idle(); #1;
      chk("alloc_valid", {31'd0, rs1_rat_valid}, 1);
      chk("alloc_tag", {27'd0, rs1_Paddr}, 3);
      chk("alloc_cnt", {26'd0, mapped_cnt}, 1);

      // commit x5 tag 3 with bypass on both sources
      do_commit(5, 3, 32'hDEAD_BEEF); rs2_addr = 5; #1;
      chk("byp_rs1_valid", {31'd0, rs1_rat_valid}, 0);
      chk("byp_rs1_value", rs1_value_fromGPR, 32'hDEAD_BEEF);
      chk("byp_rs2_value", rs2_value_fromGPR, 32'hDEAD_BEEF);
      tick(); idle(); #1;
      chk("rel_valid", {31'd0, rs1_rat_valid}, 0);
      chk("rel_gpr", rs1_value_fromGPR, 32'hDEAD_BEEF);
      chk("rel_cnt", {26'd0, mapped_cnt}, 0);

      // x7 -> tag 2, re-mapped to tag 9, then older tag 2 commits
      do_alloc(7, 2); tick();
      do_alloc(7, 9); tick(); idle();
      do_commit(7, 2, 32'h1234_5678); rs1_addr = 7; #1;
      chk("old_nobyp_valid", {31'd0, rs1_rat_valid}, 1);
      chk("old_nobyp_value", rs1_value_fromGPR, 0);
      tick(); idle(); #1;
      chk("old_keep_valid", {31'd0, rs1_rat_valid}, 1);
      chk("old_keep_tag", {27'd0, rs1_Paddr}, 9);
      chk("old_gpr", rs1_value_fromGPR, 32'h1234_5678);
      chk("old_cnt", {26'd0, mapped_cnt}, 1);

      // release and re-allocate x7 in the same cycle: allocation wins
      do_commit(7, 9, 32'h0000_0077); do_alloc(7, 4);
      tick(); idle(); #1;
      chk("race_valid", {31'd0, rs1_rat_valid}, 1);
      chk("race_tag", {27'd0, rs1_Paddr}, 4);
      chk("race_cnt", {26'd0, mapped_cnt}, 1);

      // taken branch flush with link write to x1 and a discarded allocation
      do_alloc(10, 5); tick(); idle(); #1;
      chk("pre_flush_cnt", {26'd0, mapped_cnt}, 2);
      do_commit(1, 20, 32'h0000_0044); commit_br_taken = 1; commit_br_addr = 32'h80;
      do_alloc(12, 6);
      tick(); idle(); rs1_addr = 7; rs2_addr = 12; #1;
      chk("br_flush", {31'd0, flush}, 1);
      chk("br_redirect", redirect_pc, 32'h80);
      chk("br_cnt", {26'd0, mapped_cnt}, 0);
      chk("br_x7_valid", {31'd0, rs1_rat_valid}, 0);
      chk("br_x12_valid", {31'd0, rs2_rat_valid}, 0);
      rs1_addr = 1; #1;
      chk("br_link_gpr", rs1_value_fromGPR, 32'h44);
      tick();
      chk("br_flush_drop", {31'd0, flush}, 0);
      chk("br_redirect_hold", redirect_pc, 32'h80);

      // exception beats branch for the redirect target
      commit_en = 1; commit_br_taken = 1; commit_exp_en = 1; commit_br_addr = 32'h200;
      tick(); idle(); #1;
      chk("exp_flush", {31'd0, flush}, 1);
      chk("exp_redirect", redirect_pc, 32'h100);
      tick();
      chk("exp_flush_drop", {31'd0, flush}, 0);

      // x0 is never mapped and never written
      do_alloc(0, 7); do_commit(0, 7, 32'hFFFF_FFFF); rs1_addr = 0; #1;
      chk("x0_byp_value", rs1_value_fromGPR, 0);
      tick(); idle(); #1;
      chk("x0_valid", {31'd0, rs1_rat_valid}, 0);
      chk("x0_value", rs1_value_fromGPR, 0);
      chk("x0_cnt", {26'd0, mapped_cnt}, 0);

      // asynchronous reset in the middle of an allocate/commit
      do_alloc(9, 1); do_commit(1, 20, 32'h5555_5555); rs1_addr = 1; rs2_addr = 9;
      #1 rst_n = 0; #1;
      chk("mid_rst_gpr", rs1_value_fromGPR, 0);
      chk("mid_rst_cnt", {26'd0, mapped_cnt}, 0);
      chk("mid_rst_redirect", redirect_pc, 0);
      idle();
      @(negedge clk); rst_n = 1;
      tick(); #1;
      chk("post_rst_valid", {31'd0, rs2_rat_valid}, 0);
      chk("post_rst_cnt", {26'd0, mapped_cnt}, 0);
      chk("post_rst_gpr", rs1_value_fromGPR, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
